mem_line_scheduler: RTL and testbench

// Schedules line-sized transfers on the single DDR2 MCB command port shared by
// the background subtractor. There are four requesters: display line preload
// (read), capture line (write), background-model line read, and background-model

---
 rtl/mem_line_scheduler.sv | 174 +++++++++++++++++
 tb/tb_mem_line_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_scheduler.sv
// Line-transfer scheduler for the shared MCB command port: four requesters split
// their lines into fixed bursts; display preloads preempt the others at burst edges.
module mem_line_scheduler #(
  parameter int          LINE_WORDS  = 640,
  parameter int          BURST_LEN   = 32,
  parameter int          LINE_STRIDE = 4096,
  parameter logic [29:0] DISP_BASE   = 30'h0000000,
  parameter logic [29:0] CAP_BASE    = 30'h0200000,
  parameter logic [29:0] BG_BASE     = 30'h0400000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_req,
  input  logic [10:0] disp_line,
  input  logic        cap_req,
  input  logic [10:0] cap_line,
  input  logic        bgr_req,
  input  logic        bgw_req,
  input  logic [10:0] bg_line,
  input  logic        mcb_cmd_full,
  input  logic [6:0]  mcb_wr_count,
  input  logic [6:0]  mcb_rd_count,
  output logic        mcb_cmd_en,
  output logic [2:0]  mcb_cmd_instr,
  output logic [5:0]  mcb_cmd_bl,
  output logic [29:0] mcb_cmd_addr,
  output logic [3:0]  done,
  output logic        busy,
  output logic [3:0]  overrun
);

  // state | meaning
  // IDLE  | nothing selected, waiting for any pending request
  // ARB   | pick highest-priority pending requester, load its burst address
  // CHECK | wait for command slot and data FIFO room
  // ISSUE | command strobe high for this single cycle
  // NEXT  | advance burst index, finish line, or yield to display

  localparam int              NB       = LINE_WORDS / BURST_LEN;
  localparam int              BI_W     = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BI_W-1:0] BI_LAST  = BI_W'(NB - 1);
  localparam logic [29:0]     STRIDE30 = 30'(LINE_STRIDE);
  localparam logic [29:0]     BSTEP    = 30'(BURST_LEN * 4);
  localparam logic [6:0]      WR_ROOM  = 7'(BURST_LEN);
  localparam logic [6:0]      RD_ROOM  = 7'(64 - BURST_LEN);

  typedef enum logic [2:0] {IDLE, ARB, CHECK, ISSUE, NEXT} state_t;

  state_t          state;
  logic [3:0]      pending;
  logic [1:0]      cur;
  logic [10:0]     line_q [4];
  logic [BI_W-1:0] bi_q   [4];

  logic [3:0]      req;
  logic [10:0]     line_in [4];
  logic [3:0]      clr_mask;
  logic [3:0]      pend_kept;
  logic [3:0]      accept;
  logic [3:0]      ovr_hit;
  logic [1:0]      arb_sel;
  logic            last_burst;
  logic            room;
  logic [BI_W-1:0] bi_inc;

  // Requester index order {bgw, bgr, cap, disp}; odd indexes are the write jobs.
  function automatic logic [29:0] burst_addr(input logic [1:0] id, input logic [10:0] ln,
                                             input logic [BI_W-1:0] b);
    logic [29:0] base;
    case (id)
      2'd0:    base = DISP_BASE;
      2'd1:    base = CAP_BASE;
      default: base = BG_BASE;
    endcase
    return base + ({19'd0, ln} * STRIDE30) + (30'(b) * BSTEP);
  endfunction

  assign req        = {bgw_req, bgr_req, cap_req, disp_req};
  assign line_in[0] = disp_line;
  assign line_in[1] = cap_line;
  assign line_in[2] = bg_line;
  assign line_in[3] = bg_line;

  assign last_burst = (bi_q[cur] == BI_LAST);
  assign bi_inc     = bi_q[cur] + BI_W'(1);
  assign room       = cur[0] ? (mcb_wr_count >= WR_ROOM) : (mcb_rd_count <= RD_ROOM);

  // A finishing job frees its slot before a same-edge request is judged.
  always_comb begin
    clr_mask = '0;
    if (state == NEXT && last_burst) clr_mask[cur] = 1'b1;
  end

  assign pend_kept = pending & ~clr_mask;
  assign accept    = req & ~pend_kept;
  assign ovr_hit   = req & pend_kept;

  always_comb begin
    arb_sel = 2'd3;
    if (pending[0])      arb_sel = 2'd0;
    else if (pending[1]) arb_sel = 2'd1;
    else if (pending[2]) arb_sel = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      cur           <= '0;
      mcb_cmd_en    <= 1'b0;
      mcb_cmd_instr <= '0;
      mcb_cmd_bl    <= '0;
      mcb_cmd_addr  <= '0;
      done          <= '0;
      busy          <= 1'b0;
      overrun       <= '0;
      for (int i = 0; i < 4; i++) begin
        line_q[i] <= '0;
        bi_q[i]   <= '0;
      end
    end else begin
      mcb_cmd_bl <= 6'(BURST_LEN - 1);
      done       <= '0;
      pending    <= pend_kept | accept;
      overrun    <= overrun | ovr_hit;
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) line_q[i] <= line_in[i];
      end

      case (state)
        IDLE: begin
          if (|pending) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          cur           <= arb_sel;
          mcb_cmd_instr <= arb_sel[0] ? 3'b000 : 3'b001;
          mcb_cmd_addr  <= burst_addr(arb_sel, line_q[arb_sel], bi_q[arb_sel]);
          state         <= CHECK;
        end
        CHECK: begin
          if (!mcb_cmd_full && room) begin
            mcb_cmd_en <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mcb_cmd_en <= 1'b0;
          state      <= NEXT;
        end
        NEXT: begin
          if (last_burst) begin
            bi_q[cur] <= '0;
            done[cur] <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            bi_q[cur] <= bi_inc;
            if (pending[0] && cur != 2'd0) begin
              state <= ARB;
            end else begin
              mcb_cmd_addr <= burst_addr(cur, line_q[cur], bi_inc);
              state        <= CHECK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_scheduler.sv
// Bench for mem_line_scheduler: directed line sequences, a back-pressure vector
// table, and a randomized run against a per-requester address scoreboard.
module tb_mem_line_scheduler;

  localparam int          NB      = 20;
  localparam int          BL      = 32;
  localparam logic [29:0] BG_TEST = 30'h3FFFF000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 0, cap_req = 0, bgr_req = 0, bgw_req = 0;
  logic [10:0] disp_line = 0, cap_line = 0, bg_line = 0;
  logic        mcb_cmd_full = 0;
  logic [6:0]  mcb_wr_count = 7'd64, mcb_rd_count = 7'd0;
  logic        mcb_cmd_en;
  logic [2:0]  mcb_cmd_instr;
  logic [5:0]  mcb_cmd_bl;
  logic [29:0] mcb_cmd_addr;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  overrun;

  mem_line_scheduler #(.BG_BASE(BG_TEST)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_line(disp_line),
    .cap_req(cap_req), .cap_line(cap_line),
    .bgr_req(bgr_req), .bgw_req(bgw_req), .bg_line(bg_line),
    .mcb_cmd_full(mcb_cmd_full), .mcb_wr_count(mcb_wr_count), .mcb_rd_count(mcb_rd_count),
    .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr), .mcb_cmd_bl(mcb_cmd_bl),
    .mcb_cmd_addr(mcb_cmd_addr), .done(done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] instr; logic [29:0] addr; logic [31:0] cyc;} cmd_t;
  typedef struct packed {logic [3:0] d; logic [15:0] n;} done_t;
  typedef struct {logic is_wr; logic full; logic [6:0] wr; logic [6:0] rd; logic exp_issue;} bp_vec_t;

  cmd_t        cmd_q[$];
  done_t       done_q[$];
  logic [29:0] exp_q[4][$];
  logic [3:0]  mp = '0;
  logic [3:0]  exp_ovr = '0;
  logic        sb_en = 0;
  logic        prev_en = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference address: plain arithmetic, folded into the 30-bit byte space.
  function automatic logic [29:0] model_addr(input int id, input int ln, input int b);
    longint base;
    longint a;
    base = (id == 0) ? 64'h0 : (id == 1) ? 64'h200000 : longint'(BG_TEST);
    a = base + longint'(ln) * 4096 + longint'(b) * BL * 4;
    return 30'(a & 64'h3FFF_FFFF);
  endfunction

  task automatic sb_cmd(input logic [2:0] instr, input logic [29:0] addr);
    int c0, c1;
    logic hit;
    c0 = (instr == 3'b001) ? 0 : 1;
    c1 = c0 + 2;
    hit = 0;
    if (exp_q[c0].size() > 0 && exp_q[c0][0] == addr) begin
      void'(exp_q[c0].pop_front());
      hit = 1;
    end else if (exp_q[c1].size() > 0 && exp_q[c1][0] == addr) begin
      void'(exp_q[c1].pop_front());
      hit = 1;
    end
    chk($sformatf("sb_cmd_addr_%0h_instr_%0d", addr, instr), 64'(hit), 64'd1);
  endtask

  task automatic sb_done(input logic [3:0] d);
    for (int i = 0; i < 4; i++) begin
      if (d[i]) begin
        chk($sformatf("sb_done_left_%0d", i), 64'(exp_q[i].size()), 64'd0);
        chk($sformatf("sb_done_pend_%0d", i), 64'(mp[i]), 64'd1);
        mp[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (mcb_cmd_en) begin
        cmd_q.push_back('{mcb_cmd_instr, mcb_cmd_addr, 32'(cyc)});
        chk("cmd_bl", 64'(mcb_cmd_bl), 64'd31);
        chk("cmd_en_width", 64'(prev_en), 64'd0);
        if (sb_en) sb_cmd(mcb_cmd_instr, mcb_cmd_addr);
      end
      if (done != 4'd0) begin
        done_q.push_back('{done, 16'(cmd_q.size())});
        if (sb_en) sb_done(done);
      end
      prev_en = mcb_cmd_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 0;
    disp_req = 0; cap_req = 0; bgr_req = 0; bgw_req = 0;
    mcb_cmd_full = 0; mcb_wr_count = 7'd64; mcb_rd_count = 7'd0;
    sb_en = 0;
    repeat (2) @(posedge clk);
    cmd_q.delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_req(input int i, input logic [10:0] ln);
    case (i)
      0: begin disp_req = 1; disp_line = ln; end
      1: begin cap_req = 1; cap_line = ln; end
      2: begin bgr_req = 1; bg_line = ln; end
      default: begin bgw_req = 1; bg_line = ln; end
    endcase
  endtask

  task automatic pulse(input int i, input logic [10:0] ln);
    @(posedge clk); #1;
    set_req(i, ln);
    @(posedge clk); #1;
    disp_req = 0; cap_req = 0; bgr_req = 0; bgw_req = 0;
  endtask

  task automatic wait_done(input string name, input int n, input int limit);
    int c = 0;
    while (done_q.size() < n && c < limit) begin
      @(negedge clk); #1;
      c++;
    end
    chk(name, 64'(done_q.size() >= n), 64'd1);
  endtask

  bp_vec_t vecs[8];

  initial begin
    #200000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, c;
    logic got;
    cmd_t exp_list[$];

    vecs[0] = '{1'b1, 1'b0, 7'd31, 7'd0,  1'b0};
    vecs[1] = '{1'b1, 1'b0, 7'd32, 7'd0,  1'b1};
    vecs[2] = '{1'b0, 1'b0, 7'd64, 7'd33, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 7'd64, 7'd32, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 7'd64, 7'd0,  1'b0};
    vecs[5] = '{1'b0, 1'b1, 7'd64, 7'd0,  1'b0};
    vecs[6] = '{1'b1, 1'b0, 7'd0,  7'd64, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 7'd0,  7'd0,  1'b1};

    // reset state
    #12;
    chk("rst_outputs", {mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_addr, done, busy, overrun}, 64'd0);
    do_reset();
    chk("rst_idle_busy", 64'(busy), 64'd0);

    // single display line, latency and burst cadence
    pulse(0, 11'd5);
    @(posedge clk); #1 chk("t1_lat_e1", 64'(mcb_cmd_en), 64'd0);
    @(posedge clk); #1 chk("t1_lat_e2", 64'(mcb_cmd_en), 64'd0);
    @(posedge clk); #1 chk("t1_lat_e3", 64'(mcb_cmd_en), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_wait", 1, 300);
    repeat (10) @(posedge clk);
    #1;
    chk("t1_ncmd", 64'(cmd_q.size()), 64'd20);
    chk("t1_ndone", 64'(done_q.size()), 64'd1);
    chk("t1_done_id", 64'(done_q[0].d), 64'd1);
    chk("t1_done_after", 64'(done_q[0].n), 64'd20);
    chk("t1_cadence", 64'(cmd_q[1].cyc - cmd_q[0].cyc), 64'd3);
    for (int b = 0; b < 20 && b < cmd_q.size(); b++) begin
      chk($sformatf("t1_addr%0d", b), 64'(cmd_q[b].addr), 64'(model_addr(0, 5, b)));
      chk($sformatf("t1_instr%0d", b), 64'(cmd_q[b].instr), 64'd1);
    end
    chk("t1_busy_end", 64'(busy), 64'd0);

    // display preempts capture after its third burst
    do_reset();
    pulse(1, 11'd2);
    cnt = 0; c = 0;
    while (cnt < 3 && c < 200) begin
      @(negedge clk);
      if (mcb_cmd_en) cnt++;
      c++;
    end
    chk("t2_reach3", 64'(cnt), 64'd3);
    disp_req = 1; disp_line = 11'd7;
    @(posedge clk); #1 disp_req = 0;
    wait_done("t2_wait", 2, 800);
    exp_list.delete();
    for (int b = 0; b < 3; b++)   exp_list.push_back('{3'b000, model_addr(1, 2, b), 32'd0});
    for (int b = 0; b < NB; b++)  exp_list.push_back('{3'b001, model_addr(0, 7, b), 32'd0});
    for (int b = 3; b < NB; b++)  exp_list.push_back('{3'b000, model_addr(1, 2, b), 32'd0});
    chk("t2_ncmd", 64'(cmd_q.size()), 64'(exp_list.size()));
    for (int k = 0; k < exp_list.size() && k < cmd_q.size(); k++) begin
      chk($sformatf("t2_cmd%0d", k), {31'd0, cmd_q[k].instr, cmd_q[k].addr},
          {31'd0, exp_list[k].instr, exp_list[k].addr});
    end
    chk("t2_resume_addr", 64'(cmd_q[23].addr), 64'h202180);
    chk("t2_done_first", 64'(done_q[0].d), 64'd1);
    chk("t2_done_second", 64'(done_q[1].d), 64'd2);

    // back-pressure table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      mcb_cmd_full = vecs[v].full;
      mcb_wr_count = vecs[v].wr;
      mcb_rd_count = vecs[v].rd;
      pulse(vecs[v].is_wr ? 1 : 0, 11'd1);
      repeat (8) @(posedge clk);
      #1;
      chk($sformatf("t3_v%0d_issue", v), 64'(cmd_q.size() > 0), 64'(vecs[v].exp_issue));
      if (!vecs[v].exp_issue) begin
        chk($sformatf("t3_v%0d_busy", v), 64'(busy), 64'd1);
        @(negedge clk);
        mcb_cmd_full = 0; mcb_wr_count = 7'd32; mcb_rd_count = 7'd32;
        @(posedge clk); #1;
        chk($sformatf("t3_v%0d_release", v), 64'(mcb_cmd_en), 64'd1);
      end
    end

    // request in the done cycle is accepted
    do_reset();
    pulse(0, 11'd4);
    got = 0; c = 0;
    while (!got && c < 300) begin
      @(negedge clk);
      c++;
      if (done[0]) got = 1;
    end
    chk("t4_done_seen", 64'(got), 64'd1);
    disp_req = 1; disp_line = 11'd6;
    @(posedge clk); #1 disp_req = 0;
    wait_done("t4_wait2", 2, 300);
    chk("t4_no_overrun", 64'(overrun), 64'd0);
    chk("t4_ncmd", 64'(cmd_q.size()), 64'd40);
    chk("t4_second_addr", 64'(cmd_q[20].addr), 64'(model_addr(0, 6, 0)));

    // overrun while pending keeps the original line
    do_reset();
    mcb_cmd_full = 1;
    pulse(0, 11'd3);
    pulse(0, 11'd9);
    chk("t4_overrun_set", 64'(overrun), 64'd1);
    mcb_cmd_full = 0;
    wait_done("t4_wait3", 1, 300);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_overrun_sticky", 64'(overrun), 64'd1);
    chk("t4_orig_first", 64'(cmd_q[0].addr), 64'h3000);
    chk("t4_orig_last", 64'(cmd_q[19].addr), 64'(model_addr(0, 3, 19)));
    chk("t4_one_job", 64'(cmd_q.size()), 64'd20);

    // asynchronous reset during ISSUE
    do_reset();
    pulse(0, 11'd1);
    got = 0; c = 0;
    while (!got && c < 50) begin
      @(negedge clk);
      c++;
      if (mcb_cmd_en) got = 1;
    end
    chk("t5_in_issue", 64'(got), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("t5_cmd_en_drop", 64'(mcb_cmd_en), 64'd0);
    chk("t5_busy_drop", 64'(busy), 64'd0);
    chk("t5_done_drop", 64'(done), 64'd0);
    cmd_q.delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (30) @(posedge clk);
    #1;
    chk("t5_no_cmd", 64'(cmd_q.size()), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

    // background address wrap
    do_reset();
    pulse(2, 11'd2047);
    wait_done("t6_wait_r", 1, 300);
    pulse(3, 11'd2047);
    wait_done("t6_wait_w", 2, 300);
    chk("t6_rd_first", {31'd0, cmd_q[0].instr, cmd_q[0].addr}, {31'd0, 3'b001, 30'h07FE000});
    chk("t6_rd_last", 64'(cmd_q[19].addr), 64'h07FE980);
    chk("t6_wr_first", {31'd0, cmd_q[20].instr, cmd_q[20].addr}, {31'd0, 3'b000, 30'h07FE000});
    chk("t6_no_x", 64'($isunknown({mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_addr, done, busy, overrun})), 64'd0);
    chk("t6_done_order", {60'd0, done_q[0].d}, 64'd4);

    // randomized traffic against the scoreboard
    do_reset();
    mp = '0;
    exp_ovr = '0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    sb_en = 1;
    for (int k = 0; k < 3000; k++) begin
      logic [10:0] bgl;
      logic [10:0] ln;
      int r;
      @(posedge clk); #1;
      disp_req = 0; cap_req = 0; bgr_req = 0; bgw_req = 0;
      mcb_cmd_full = ($urandom_range(0, 3) == 0);
      mcb_wr_count = 7'($urandom_range(0, 64));
      mcb_rd_count = 7'($urandom_range(0, 64));
      bgl = 11'(100 + $urandom_range(0, 31));
      bg_line = bgl;
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 59);
        ln = (i == 0) ? 11'($urandom_range(0, 15)) : (i == 1) ? 11'($urandom_range(0, 63)) : bgl;
        if (r == 0 && !mp[i]) begin
          set_req(i, ln);
          mp[i] = 1'b1;
          for (int b = 0; b < NB; b++) exp_q[i].push_back(model_addr(i, int'(ln), b));
        end else if (r == 1 && mp[i] && exp_q[i].size() > 1) begin
          set_req(i, ln);
          exp_ovr[i] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    disp_req = 0; cap_req = 0; bgr_req = 0; bgw_req = 0;
    mcb_cmd_full = 0; mcb_wr_count = 7'd64; mcb_rd_count = 7'd0;
    c = 0;
    while (mp != 4'd0 && c < 5000) begin
      @(negedge clk); #1;
      c++;
    end
    chk("rnd_drain", 64'(mp), 64'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rnd_left_%0d", i), 64'(exp_q[i].size()), 64'd0);
    chk("rnd_overrun", 64'(overrun), 64'(exp_ovr));
    sb_en = 0;
    chk("rnd_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
